// File: rtl/ft_emu_pkg.sv
// ft_emu_pkg: shared types and constants for the FT600 chip-side emulator.
//   wr_state_e : write-direction FSM states (FPGA -> emulator).
//   rd_state_e : read-direction FSM states (emulator -> FPGA).
//   ERR_W      : width of the saturating protocol-error counter.
//   sat_inc    : saturating increment helper for ERR_W-wide counters.
package ft_emu_pkg;

    typedef enum logic [0:0] {
        W_GAP,
        W_READY
    } wr_state_e;

    typedef enum logic [1:0] {
        R_GAP,
        R_IDLE,
        R_AVAIL
    } rd_state_e;

    localparam int unsigned ERR_W = 16;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ft_emu_if.sv
// ft_emu_if: FT600 245-style synchronous FIFO bus plus the host-side streaming ports.
//   Bus   : txe_n, rxf_n (chip status), wr_n, rd_n, oe_n (FPGA strobes),
//           ft_din/be_din (FPGA -> chip), ft_dout/be_dout/dout_oe (chip -> FPGA).
//   Host  : host_tx_* (host -> out-FIFO), host_rx_* (in-FIFO -> host), valid/ready.
//   Modports: slave = the emulator, master = FPGA core and host model facing it.
interface ft_emu_if #(
    parameter int unsigned FT_DATA_WIDTH = 32
);
    localparam int unsigned BE_W = FT_DATA_WIDTH / 8;

    logic                     txe_n;
    logic                     rxf_n;
    logic                     wr_n;
    logic                     rd_n;
    logic                     oe_n;
    logic [FT_DATA_WIDTH-1:0] ft_din;
    logic [BE_W-1:0]          be_din;
    logic [FT_DATA_WIDTH-1:0] ft_dout;
    logic [BE_W-1:0]          be_dout;
    logic                     dout_oe;

    logic [FT_DATA_WIDTH-1:0] host_tx_data;
    logic                     host_tx_valid;
    logic                     host_tx_ready;
    logic [FT_DATA_WIDTH-1:0] host_rx_data;
    logic [BE_W-1:0]          host_rx_be;
    logic                     host_rx_valid;
    logic                     host_rx_ready;

    modport slave (
        output txe_n, rxf_n, ft_dout, be_dout, dout_oe,
        output host_tx_ready, host_rx_data, host_rx_be, host_rx_valid,
        input  wr_n, rd_n, oe_n, ft_din, be_din,
        input  host_tx_data, host_tx_valid, host_rx_ready
    );

    modport master (
        input  txe_n, rxf_n, ft_dout, be_dout, dout_oe,
        input  host_tx_ready, host_rx_data, host_rx_be, host_rx_valid,
        output wr_n, rd_n, oe_n, ft_din, be_din,
        output host_tx_data, host_tx_valid, host_rx_ready
    );

endinterface

// File: rtl/ft_emu_fifo.sv
// ft_emu_fifo: synchronous show-ahead FIFO with a registered head output.
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO).
//   push, wdata    : write side; push is ignored when full unless a pop happens too.
//   pop            : read side; ignored when empty.
//   rdata          : current head word (registered), valid whenever empty=0.
//   count/full/empty : occupancy status.
// DEPTH must be a power of two.
module ft_emu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rdata_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rptr_d  = rptr_q + AW'(do_pop);

    // Next head: a word pushed into a slot that becomes the head this cycle is
    // forwarded so the registered output never lags the memory.
    always_comb begin
        head_d = mem[rptr_d];
        if (do_push && (wptr_q == rptr_d)) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            rptr_q  <= rptr_d;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (do_push || do_pop) begin
                rdata_q <= head_d;
            end
        end
    end

    assign rdata = rdata_q;
    assign count = count_q;

endmodule

// File: rtl/ft_emu.sv
// ft_emu: chip-side emulator of the FT600 245-style synchronous FIFO bus.
// Faces ft600_fsm on the bus side and exposes host streaming ports instead of USB.
//   clk, reset : FT bus clock, synchronous active-high reset (discards buffered data).
//   bus        : ft_emu_if.slave -- txe_n/rxf_n/ft_dout/be_dout/dout_oe driven (registered),
//                wr_n/rd_n/oe_n/ft_din/be_din sampled; host_tx_* feeds the out-FIFO,
//                host_rx_* drains the in-FIFO.
//   err_count  : saturating count of cycles with at least one protocol violation.
// Optional macro FT_EMU_STATS_EN adds wr_words, rd_words (wrapping word counts) and
// gap_events (saturating count of cycles in which either FSM entered its gap).
module ft_emu
    import ft_emu_pkg::*;
#(
    parameter int unsigned FT_DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH     = 16,
    parameter int unsigned PKT_WORDS     = 4096,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             reset,
    ft_emu_if.slave          bus,
    output logic [ERR_W-1:0] err_count
`ifdef FT_EMU_STATS_EN
    ,
    output logic [31:0]      wr_words,
    output logic [31:0]      rd_words,
    output logic [15:0]      gap_events
`endif
);

    localparam int unsigned BE_W    = FT_DATA_WIDTH / 8;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned BURST_W = $clog2(PKT_WORDS + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [BURST_W-1:0] LAST_WORD = BURST_W'(PKT_WORDS - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT  = GAP_W'(GAP_CYCLES);

    wr_state_e          w_state;
    rd_state_e          r_state;
    logic [GAP_W-1:0]   w_gap, r_gap;
    logic [BURST_W-1:0] wr_burst, rd_burst;
    logic               txe_n_q, rxf_n_q, dout_oe_q;
    logic [ERR_W-1:0]   err_q;

    logic [FT_DATA_WIDTH+BE_W-1:0] in_rdata;
    logic [CNT_W-1:0]   in_count, out_count, in_cnt_nx, out_cnt_nx;
    logic               in_full, in_empty, out_full, out_empty;
    logic               wr_acc, rd_acc, in_pop, out_push, viol;
    logic               w_enter_gap, r_enter_gap;

    // Bus strobes that also break protocol are refused, so violations never move data.
    assign wr_acc   = !bus.wr_n && !txe_n_q && bus.oe_n && !in_full;
    assign rd_acc   = !bus.rd_n && !bus.oe_n && !rxf_n_q && dout_oe_q && !out_empty;
    assign in_pop   = !in_empty && bus.host_rx_ready;
    assign out_push = bus.host_tx_valid && !out_full;

    // Occupancy after this cycle's push/pop, used for look-ahead flow control.
    assign in_cnt_nx  = in_count + CNT_W'(wr_acc) - CNT_W'(in_pop);
    assign out_cnt_nx = out_count + CNT_W'(out_push) - CNT_W'(rd_acc);

    assign w_enter_gap = (w_state == W_READY) &&
                         ((in_cnt_nx == FULL_CNT) || (wr_acc && (wr_burst == LAST_WORD)));
    assign r_enter_gap = (r_state == R_AVAIL) && rd_acc && (rd_burst == LAST_WORD);

    assign viol = (!bus.wr_n && txe_n_q) || (!bus.rd_n && rxf_n_q) ||
                  (!bus.rd_n && !dout_oe_q) || (!bus.wr_n && !bus.oe_n);

    ft_emu_fifo #(
        .WIDTH (FT_DATA_WIDTH + BE_W),
        .DEPTH (BUF_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_acc),
        .wdata ({bus.be_din, bus.ft_din}),
        .pop   (in_pop),
        .rdata (in_rdata),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    ft_emu_fifo #(
        .WIDTH (FT_DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .wdata (bus.host_tx_data),
        .pop   (rd_acc),
        .rdata (bus.ft_dout),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    // Write FSM: txe_n low only in W_READY; leaves early so an accepted word always fits.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state  <= W_GAP;
            w_gap    <= GAP_INIT;
            wr_burst <= '0;
            txe_n_q  <= 1'b1;
        end else begin
            unique case (w_state)
                W_GAP: begin
                    if (w_gap > GAP_W'(1)) begin
                        w_gap <= w_gap - GAP_W'(1);
                    end else if (in_cnt_nx != FULL_CNT) begin
                        w_state <= W_READY;
                        txe_n_q <= 1'b0;
                    end
                end
                W_READY: begin
                    if (w_enter_gap) begin
                        w_state  <= W_GAP;
                        w_gap    <= GAP_INIT;
                        wr_burst <= '0;
                        txe_n_q  <= 1'b1;
                    end else if (wr_acc) begin
                        wr_burst <= wr_burst + BURST_W'(1);
                    end
                end
                default: begin
                    w_state <= W_GAP;
                    w_gap   <= GAP_INIT;
                    txe_n_q <= 1'b1;
                end
            endcase
        end
    end

    // Read FSM: dout_oe follows ~oe_n one cycle late, but only while data is offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_GAP;
            r_gap     <= GAP_INIT;
            rd_burst  <= '0;
            rxf_n_q   <= 1'b1;
            dout_oe_q <= 1'b0;
        end else begin
            dout_oe_q <= 1'b0;
            unique case (r_state)
                R_GAP: begin
                    if (r_gap > GAP_W'(1)) begin
                        r_gap <= r_gap - GAP_W'(1);
                    end else if (out_cnt_nx != '0) begin
                        r_state   <= R_AVAIL;
                        rxf_n_q   <= 1'b0;
                        dout_oe_q <= !bus.oe_n;
                    end else begin
                        r_state <= R_IDLE;
                    end
                end
                R_IDLE: begin
                    if (out_cnt_nx != '0) begin
                        r_state   <= R_AVAIL;
                        rxf_n_q   <= 1'b0;
                        dout_oe_q <= !bus.oe_n;
                    end
                end
                R_AVAIL: begin
                    if (r_enter_gap) begin
                        r_state  <= R_GAP;
                        r_gap    <= GAP_INIT;
                        rd_burst <= '0;
                        rxf_n_q  <= 1'b1;
                    end else if (out_cnt_nx == '0) begin
                        r_state  <= R_IDLE;
                        rd_burst <= '0;
                        rxf_n_q  <= 1'b1;
                    end else begin
                        dout_oe_q <= !bus.oe_n;
                        if (rd_acc) begin
                            rd_burst <= rd_burst + BURST_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= R_GAP;
                    r_gap   <= GAP_INIT;
                    rxf_n_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (viol) begin
            err_q <= sat_inc(err_q);
        end
    end

`ifdef FT_EMU_STATS_EN
    logic [31:0] wr_words_q, rd_words_q;
    logic [15:0] gap_events_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_words_q   <= '0;
            rd_words_q   <= '0;
            gap_events_q <= '0;
        end else begin
            wr_words_q <= wr_words_q + 32'(wr_acc);
            rd_words_q <= rd_words_q + 32'(rd_acc);
            if (w_enter_gap || r_enter_gap) begin
                gap_events_q <= sat_inc(gap_events_q);
            end
        end
    end

    assign wr_words   = wr_words_q;
    assign rd_words   = rd_words_q;
    assign gap_events = gap_events_q;
`endif

    assign bus.txe_n         = txe_n_q;
    assign bus.rxf_n         = rxf_n_q;
    assign bus.dout_oe       = dout_oe_q;
    assign bus.be_dout       = {BE_W{1'b1}};
    assign bus.host_tx_ready = !out_full;
    assign bus.host_rx_valid = !in_empty;
    assign bus.host_rx_data  = in_rdata[FT_DATA_WIDTH-1:0];
    assign bus.host_rx_be    = in_rdata[FT_DATA_WIDTH+BE_W-1:FT_DATA_WIDTH];
    assign err_count         = err_q;

endmodule

// File: tb/tb_ft_emu.sv
// tb_ft_emu: scoreboard bench for ft_emu (BUF_DEPTH=16, PKT_WORDS=8, GAP_CYCLES=4).
// Stimulus pushes expected words into queues; a negedge monitor pops and compares
// whenever the DUT hands a word to the host or the FPGA consumes one from the bus.
module tb_ft_emu;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] err_count;
`ifdef FT_EMU_STATS_EN
    logic [31:0] wr_words, rd_words;
    logic [15:0] gap_events;
`endif

    ft_emu_if #(.FT_DATA_WIDTH(DW)) bus ();

    ft_emu #(
        .FT_DATA_WIDTH (DW),
        .BUF_DEPTH     (16),
        .PKT_WORDS     (8),
        .GAP_CYCLES    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_count (err_count)
`ifdef FT_EMU_STATS_EN
        ,
        .wr_words   (wr_words),
        .rd_words   (rd_words),
        .gap_events (gap_events)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] exp_rx[$];
    logic [31:0] exp_ft[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compares every word leaving the DUT against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.host_rx_valid && bus.host_rx_ready) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL host_rx_unexpected: got %0h expected none",
                             {bus.host_rx_be, bus.host_rx_data});
                end else begin
                    check("host_rx_word", {28'd0, bus.host_rx_be, bus.host_rx_data},
                          {28'd0, exp_rx.pop_front()});
                end
            end
            if (!bus.rd_n && !bus.oe_n && !bus.rxf_n && bus.dout_oe) begin
                if (exp_ft.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ft_read_unexpected: got %0h expected none", bus.ft_dout);
                end else begin
                    check("ft_read_word", {32'd0, bus.ft_dout}, {32'd0, exp_ft.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FPGA-side writer: drives the next word only while txe_n is low.
    task automatic fpga_write(input int n, input logic [31:0] base, input int budget,
                              output int acc, output int first_burst);
        int i;
        bit gap_seen;
        i = 0;
        gap_seen = 0;
        first_burst = 0;
        tick();
        for (int c = 0; c < budget && i < n; c++) begin
            if (!bus.txe_n) begin
                bus.wr_n   = 1'b0;
                bus.ft_din = base + 32'(i);
                bus.be_din = 4'hF;
            end else begin
                bus.wr_n = 1'b1;
                if (i > 0) gap_seen = 1;
            end
            tick();
            if (!bus.wr_n) begin
                i++;
                if (!gap_seen) first_burst++;
            end
        end
        bus.wr_n = 1'b1;
        acc = i;
    endtask

    task automatic drain_rx(input string name);
        int c;
        c = 0;
        while (exp_rx.size() != 0 && c < 100) begin
            tick();
            c++;
        end
        check(name, 64'(exp_rx.size()), 64'd0);
    endtask

    task automatic host_push(input logic [31:0] d);
        int c;
        c = 0;
        bus.host_tx_valid = 1'b1;
        bus.host_tx_data  = d;
        while (!bus.host_tx_ready && c < 50) begin
            tick();
            c++;
        end
        check("host_tx_ready", 64'(bus.host_tx_ready), 64'd1);
        exp_ft.push_back(d);
        tick();
        bus.host_tx_valid = 1'b0;
    endtask

    initial begin
        int acc, fb, c;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
        bus.ft_din = '0;
        bus.be_din = '0;
        bus.host_tx_data = '0;
        bus.host_tx_valid = 1'b0;
        bus.host_rx_ready = 1'b0;

        // Reset values and the initial gap.
        repeat (3) tick();
        @(negedge clk);
        check("rst_txe_n", 64'(bus.txe_n), 64'd1);
        check("rst_rxf_n", 64'(bus.rxf_n), 64'd1);
        check("rst_dout_oe", 64'(bus.dout_oe), 64'd0);
        check("rst_ft_dout", 64'(bus.ft_dout), 64'd0);
        check("rst_be_dout", 64'(bus.be_dout), 64'hF);
        check("rst_rx_valid", 64'(bus.host_rx_valid), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("gap_txe_high", 64'(bus.txe_n), 64'd1);
        end
        @(negedge clk);
        check("gap_txe_low", 64'(bus.txe_n), 64'd0);
        check("gap_rxf_high", 64'(bus.rxf_n), 64'd1);
        check("gap_err", 64'(err_count), 64'd0);

        // Continuous write with the host draining: bursts of 8, in order, no loss.
        bus.host_rx_ready = 1'b1;
        for (int k = 0; k < 20; k++) exp_rx.push_back({4'hF, 32'(k)});
        fpga_write(20, 32'h0, 200, acc, fb);
        check("burst_accepted", 64'(acc), 64'd20);
        check("first_burst_len", 64'(fb), 64'd8);
        drain_rx("burst_drain");

        // Host stalled: exactly BUF_DEPTH words fit, then txe_n stays high.
        bus.host_rx_ready = 1'b0;
        for (int k = 0; k < 16; k++) exp_rx.push_back({4'hF, 32'h100 + 32'(k)});
        fpga_write(16, 32'h100, 100, acc, fb);
        check("fill_accepted", 64'(acc), 64'd16);
        fpga_write(1, 32'h110, 20, acc, fb);
        check("full_refused", 64'(acc), 64'd0);
        check("full_txe_high", 64'(bus.txe_n), 64'd1);
        check("full_err", 64'(err_count), 64'd0);
        bus.host_rx_ready = 1'b1;
        drain_rx("fill_drain");

        // Host -> FPGA: turnaround then three back-to-back reads.
        host_push(32'hA);
        host_push(32'hB);
        host_push(32'hC);
        c = 0;
        while (bus.rxf_n && c < 20) begin
            tick();
            c++;
        end
        check("rxf_low", 64'(bus.rxf_n), 64'd0);
        bus.oe_n = 1'b0;
        @(negedge clk);
        check("oe_turnaround", 64'(bus.dout_oe), 64'd0);
        tick();
        check("dout_oe_on", 64'(bus.dout_oe), 64'd1);
        bus.rd_n = 1'b0;
        repeat (3) tick();
        bus.rd_n = 1'b1;
        @(negedge clk);
        check("rxf_after_last", 64'(bus.rxf_n), 64'd1);
        check("reads_consecutive", 64'(exp_ft.size()), 64'd0);
        bus.oe_n = 1'b1;

        // Protocol violations: 5 reads while rxf_n=1, one wr_n/oe_n overlap.
        tick();
        bus.rd_n = 1'b0;
        repeat (5) tick();
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b0;
        bus.oe_n   = 1'b0;
        bus.ft_din = 32'hDEAD;
        tick();
        bus.wr_n = 1'b1;
        bus.oe_n = 1'b1;
        @(negedge clk);
        check("err_count", 64'(err_count), 64'd6);
        repeat (3) tick();
        check("viol_no_data", 64'(bus.host_rx_valid), 64'd0);

        // Reset mid-burst discards buffered words.
        bus.host_rx_ready = 1'b0;
        fpga_write(3, 32'h200, 40, acc, fb);
        check("pre_reset_acc", 64'(acc), 64'd3);
        reset = 1'b1;
        exp_rx.delete();
        tick();
        @(negedge clk);
        check("midrst_txe_n", 64'(bus.txe_n), 64'd1);
        check("midrst_rx_valid", 64'(bus.host_rx_valid), 64'd0);
        check("midrst_err", 64'(err_count), 64'd0);
        tick();
        reset = 1'b0;
        exp_rx.push_back({4'hF, 32'h300});
        exp_rx.push_back({4'hF, 32'h301});
        bus.host_rx_ready = 1'b1;
        fpga_write(2, 32'h300, 40, acc, fb);
        check("post_reset_acc", 64'(acc), 64'd2);
        drain_rx("post_reset_drain");

        check("ft_queue_empty", 64'(exp_ft.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ft_emu.md
Name: ft_emu

Overview:
- Synthesizable chip-side emulator of the FT600 245-style synchronous FIFO bus; the counterpart that faces ft600_fsm.
- Owns txe_n, rxf_n and the data drive on the bus. Presents host-side streaming ports in place of USB.
- Used for in-FPGA self-test and simulation. In self-test it is muxed in place of the pins; host ports connect to a pattern generator/checker.
- Everything runs in the ft_clk domain.

Parameters:
- FT_DATA_WIDTH, 32, bus data width; byte enables are FT_DATA_WIDTH/8 bits.
- BUF_DEPTH, 16, words in each direction's internal FIFO (power of 2, >=4).
- PKT_WORDS, 4096, maximum words per burst before a forced gap.
- GAP_CYCLES, 4, cycles txe_n/rxf_n are held high between bursts (>=1).

Ports:
- clk in 1 FT bus clock.
- reset in 1 synchronous, active-high reset.
- txe_n out 1 low = emulator can accept writes.
- rxf_n out 1 low = emulator has data for the FPGA to read.
- wr_n in 1 FPGA write strobe, active low.
- rd_n in 1 FPGA read strobe, active low.
- oe_n in 1 FPGA output-enable request, active low.
- ft_din in FT_DATA_WIDTH data written by the FPGA.
- be_din in FT_DATA_WIDTH/8 byte enables written by the FPGA.
- ft_dout out FT_DATA_WIDTH data driven to the FPGA.
- be_dout out FT_DATA_WIDTH/8 byte enables driven to the FPGA (all ones).
- dout_oe out 1 emulator drives ft_dout/be_dout.
- host_tx_data in FT_DATA_WIDTH host word destined for the FPGA.
- host_tx_valid in 1 valid/ready handshake.
- host_tx_ready out 1 high when the out-FIFO is not full.
- host_rx_data out FT_DATA_WIDTH word received from the FPGA.
- host_rx_be out FT_DATA_WIDTH/8 byte enables received with that word.
- host_rx_valid out 1 valid/ready handshake.
- host_rx_ready in 1 valid/ready handshake.
- err_count out 16 saturating protocol-violation count.

Behaviour:
- Reset values:
  - txe_n=1, rxf_n=1, dout_oe=0.
  - ft_dout=0, be_dout=all ones.
  - host_rx_valid=0, err_count=0, both FIFOs empty, both FSMs in GAP with gap counter=GAP_CYCLES.
- Reset mid-burst discards all buffered data.
- All bus outputs are registered.
- Write FSM (FPGA->emulator):
  - W_GAP: txe_n=1; count down GAP_CYCLES; then go to W_READY if the in-FIFO is not full.
  - W_READY: txe_n=0.
    - Word accepted on any cycle with wr_n=0 and txe_n=0; captures ft_din/be_din into the in-FIFO.
    - Go to W_GAP when the burst counter reaches PKT_WORDS.
    - Also go to W_GAP when the in-FIFO would be full after this cycle's push/pop.
    - txe_n is high on the following cycle. The emulator never drops an accepted word.
- Read FSM (emulator->FPGA):
  - R_GAP: as W_GAP; then go to R_AVAIL if the out-FIFO is non-empty, else R_IDLE.
  - R_IDLE: rxf_n=1; go to R_AVAIL on out-FIFO non-empty.
  - R_AVAIL: rxf_n=0; ft_dout = out-FIFO head.
    - dout_oe = registered ~oe_n, giving one cycle of bus turnaround.
    - Word consumed on a cycle with rd_n=0, oe_n=0, rxf_n=0 and dout_oe=1. The head advances and the next word appears the next cycle.
    - Go to R_GAP when PKT_WORDS have been consumed.
    - Go to R_IDLE when the FIFO empties after a pop. rxf_n rises the cycle after the last pop.
- Host ports:
  - host_tx pushes when valid&&ready.
  - host_rx pops the in-FIFO when valid&&ready. host_rx_valid = in-FIFO non-empty.
  - A simultaneous push and pop on one FIFO keeps its count unchanged.
- Protocol errors (+1 each, saturating at 0xFFFF):
  - wr_n=0 while txe_n=1.
  - rd_n=0 while rxf_n=1.
  - rd_n=0 while dout_oe=0.
  - wr_n=0 and oe_n=0 in the same cycle.
  - Multiple violations in one cycle still add only 1.
  - Violating strobes have no data effect.
- Burst counters clear on entering GAP or IDLE.

Optional Feature:
- Macro FT_EMU_STATS_EN.
- Defined:
  - Adds outputs wr_words and rd_words (32 bit, wrapping) counting accepted and consumed words.
  - Adds output gap_events (16 bit, saturating).
  - All three reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ft_emu_pkg:
  - Write-FSM state type (W_GAP, W_READY).
  - Read-FSM state type (R_GAP, R_IDLE, R_AVAIL).
  - ERR_W constant = 16.
- One sub-module ft_emu_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH. Outputs: count, full, empty. Instantiated twice; the in-FIFO has width FT_DATA_WIDTH + FT_DATA_WIDTH/8.

Test Plan:
- Reset release with host idle -> txe_n=1 for 4 cycles then 0; rxf_n stays 1; err_count=0.
- PKT_WORDS=8: FPGA writes 0x0..0x13 continuously, host_rx_ready=1 -> txe_n high after word 0x7; in-order host_rx output 0x0..0x13; zero loss.
- host_rx_ready=0 with BUF_DEPTH=16 -> exactly 16 words accepted, txe_n=1; no drops, no errors.
- Host pushes 3 words (0xA,0xB,0xC); FPGA drops oe_n then rd_n a cycle later -> dout_oe rises 1 cycle after oe_n; reads A,B,C on consecutive cycles; rxf_n=1 the cycle after C.
- rd_n=0 while rxf_n=1 for 5 cycles, plus one wr_n&oe_n overlap -> err_count=6; FIFO contents unchanged.
- Reset asserted mid-write burst -> next cycle txe_n=1, host_rx_valid=0; after release the first received word is the first post-reset word.
